// File: rtl/mac_tile_pkg.sv
// Shared types and helpers for the MAC tile sequencer and its lanes.
// Sequencer state encoding, lane-index width and the saturating add.
package mac_tile_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_CLEAR = 3'd1;
   localparam state_t S_FETCH = 3'd2;
   localparam state_t S_FLUSH = 3'd3;
   localparam state_t S_DRAIN = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   function automatic int lane_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Operands arrive sign-extended to 64 bits; the caller keeps the low acc_w bits.
   // With sat clear the truncation gives two's-complement wrap for free.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int              acc_w,
                                                  input logic            sat);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (sat && (s > hi)) begin
         return hi;
      end
      if (sat && (s < lo)) begin
         return lo;
      end
      return s;
   endfunction

endpackage

// File: rtl/mac_tile_seq_lane.sv
// One signed multiply-accumulate lane with synchronous clear and
// run-time selectable saturate/wrap behaviour.
module mac_lane
   import mac_tile_pkg::*;
#(
   parameter int W     = 8,
   parameter int ACC_W = 24
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    en_i,
   input  logic                    sat_en_i,
   input  logic signed [W-1:0]     a_i,
   input  logic signed [W-1:0]     w_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [2*W-1:0]   prod;
   logic signed [63:0]      acc_ext;
   logic signed [63:0]      prod_ext;

   assign prod     = a_i * w_i;
   assign acc_ext  = {{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q};
   assign prod_ext = {{(64-2*W){prod[2*W-1]}}, prod};

   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = ACC_W'(sat_add(acc_ext, prod_ext, ACC_W, sat_en_i));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mac_tile_seq.sv
// Tile sequencer: clears N_MACS lanes, streams LEN weight/activation reads
// into them, then drains the accumulators lane by lane over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; config latched on start
// CLEAR   | zero all accumulators
// FETCH   | issue one weight+activation read per k
// FLUSH   | let the last read's MAC land
// DRAIN   | present acc[lane] until each lane is accepted
// DONE    | one-cycle done pulse
module mac_tile_seq
   import mac_tile_pkg::*;
#(
   parameter int N_MACS = 4,
   parameter int W      = 8,
   parameter int ACC_W  = 24,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic [LEN_W-1:0]               len_i,
   input  logic [ADDR_W-1:0]              w_base_i,
   input  logic [ADDR_W-1:0]              a_base_i,
   input  logic                           sat_en_i,
   output logic                           w_rd_en_o,
   output logic [ADDR_W-1:0]              w_rd_addr_o,
   input  logic [N_MACS*W-1:0]            w_rd_data_i,
   output logic                           a_rd_en_o,
   output logic [ADDR_W-1:0]              a_rd_addr_o,
   input  logic [W-1:0]                   a_rd_data_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [ACC_W-1:0]               out_data_o,
   output logic [lane_idx_w(N_MACS)-1:0]  out_lane_o,
   output logic                           out_last_o,
   output logic                           busy_o,
   output logic                           done_o
);

   localparam int LW = lane_idx_w(N_MACS);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  k_q, k_d;
   logic [LW-1:0]     lane_q, lane_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] w_base_q, w_base_d;
   logic [ADDR_W-1:0] a_base_q, a_base_d;
   logic              sat_q, sat_d;
   logic              mac_en_q;

   logic              fetch;
   logic              drain;
   logic              last_lane;
   logic signed [ACC_W-1:0] acc [N_MACS];

   assign fetch     = (state_q == S_FETCH);
   assign drain     = (state_q == S_DRAIN);
   assign last_lane = (lane_q == LW'(N_MACS - 1));

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      lane_d   = lane_q;
      len_d    = len_q;
      w_base_d = w_base_q;
      a_base_d = a_base_q;
      sat_d    = sat_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               len_d    = len_i;
               w_base_d = w_base_i;
               a_base_d = a_base_i;
               sat_d    = sat_en_i;
               state_d  = S_CLEAR;
            end
         end
         S_CLEAR: begin
            k_d     = '0;
            lane_d  = '0;
            state_d = (len_q != '0) ? S_FETCH : S_DRAIN;
         end
         S_FETCH: begin
            k_d = k_q + LEN_W'(1);
            if (k_q == len_q - LEN_W'(1)) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_ready_i) begin
               if (last_lane) begin
                  lane_d  = '0;
                  state_d = S_DONE;
               end else begin
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         lane_q   <= '0;
         len_q    <= '0;
         w_base_q <= '0;
         a_base_q <= '0;
         sat_q    <= 1'b0;
         mac_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         lane_q   <= lane_d;
         len_q    <= len_d;
         w_base_q <= w_base_d;
         a_base_q <= a_base_d;
         sat_q    <= sat_d;
         mac_en_q <= fetch;
      end
   end

   // Read data returns one cycle after the strobe, so the lanes accumulate on the delayed strobe.
   for (genvar i = 0; i < N_MACS; i++) begin : g_lane
      mac_lane #(
         .W     (W),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .clear_i  (state_q == S_CLEAR),
         .en_i     (mac_en_q),
         .sat_en_i (sat_q),
         .a_i      (a_rd_data_i),
         .w_i      (w_rd_data_i[i*W +: W]),
         .acc_o    (acc[i])
      );
   end

   assign w_rd_en_o   = fetch;
   assign a_rd_en_o   = fetch;
   assign w_rd_addr_o = fetch ? (w_base_q + ADDR_W'(k_q)) : '0;
   assign a_rd_addr_o = fetch ? (a_base_q + ADDR_W'(k_q)) : '0;

   assign out_valid_o = drain;
   assign out_data_o  = drain ? acc[lane_q] : '0;
   assign out_lane_o  = drain ? lane_q : '0;
   assign out_last_o  = drain & last_lane;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_mac_tile_seq.sv
// Self-checking bench for mac_tile_seq (4 lanes, 16-bit accumulators) against
// a plain-arithmetic dot-product model over bench-owned memories.
module tb_mac_tile_seq;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int AW  = 16;
   localparam int ADW = 8;
   localparam int LW  = 8;

   logic            clk, rst, start, sat, w_rd_en, a_rd_en, out_valid, out_ready;
   logic            out_last, busy, done;
   logic [LW-1:0]   len;
   logic [ADW-1:0]  wb, ab, w_rd_addr, a_rd_addr;
   logic [N*W-1:0]  w_rd_data;
   logic [W-1:0]    a_rd_data;
   logic [AW-1:0]   out_data;
   logic [1:0]      out_lane;

   logic [N*W-1:0]  wmem [256];
   logic [W-1:0]    amem [256];

   int vectors, miscompares;
   logic [AW-1:0] got_data[$];
   int  got_lane[$];
   bit  got_last[$];
   int  wa_log[$], aa_log[$];
   int  strobes, en_err, hold_err, done_cyc, done_pulses, stall_total, timeout;

   mac_tile_seq #(.N_MACS(N), .W(W), .ACC_W(AW), .ADDR_W(ADW), .LEN_W(LW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .w_base_i(wb),
      .a_base_i(ab), .sat_en_i(sat), .w_rd_en_o(w_rd_en), .w_rd_addr_o(w_rd_addr),
      .w_rd_data_i(w_rd_data), .a_rd_en_o(a_rd_en), .a_rd_addr_o(a_rd_addr),
      .a_rd_data_i(a_rd_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_lane_o(out_lane), .out_last_o(out_last),
      .busy_o(busy), .done_o(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
      if (a_rd_en) a_rd_data <= amem[a_rd_addr];
   end

   function automatic logic [AW-1:0] model_acc(int lane, int l, int wbv, int abv, bit s);
      longint acc;
      logic signed [7:0] av, wv;
      logic [31:0] word;
      logic signed [63:0] r;
      acc = 0;
      for (int k = 0; k < l; k++) begin
         av   = amem[(abv + k) % 256];
         word = wmem[(wbv + k) % 256];
         wv   = word[lane*8 +: 8];
         acc  = acc + longint'(av) * longint'(wv);
         if (s && acc > 32767) acc = 32767;
         if (s && acc < -32768) acc = -32768;
      end
      r = acc;
      return r[15:0];
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         wmem[i] = $urandom;
         amem[i] = 8'($urandom);
      end
   endtask

   task automatic run_job(input int l, input int wbv, input int abv, input bit s,
                          input int stall_lane, input int stall_n, input bit rand_rdy,
                          input int glitch_cyc);
      int cyc, stalls_left;
      bit prev_stalled;
      logic [AW-1:0] held_data;
      logic [1:0] held_lane;
      logic held_last;
      got_data.delete(); got_lane.delete(); got_last.delete();
      wa_log.delete(); aa_log.delete();
      strobes = 0; en_err = 0; hold_err = 0; done_cyc = -1; done_pulses = 0;
      stall_total = 0; timeout = 0; stalls_left = stall_n; prev_stalled = 0;
      held_data = '0; held_lane = '0; held_last = 1'b0;
      len = LW'(l); wb = ADW'(wbv); ab = ADW'(abv); sat = s; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      while (1) begin
         if (cyc == glitch_cyc) begin
            start = 1'b1; len = 8'd2; wb = 8'($urandom); ab = 8'($urandom); sat = ~s;
         end else begin
            start = 1'b0;
         end
         if (w_rd_en) begin
            strobes++;
            wa_log.push_back(int'(w_rd_addr));
            aa_log.push_back(int'(a_rd_addr));
         end
         if (w_rd_en !== a_rd_en) en_err++;
         if (out_valid) begin
            if (prev_stalled && (out_data !== held_data || out_lane !== held_lane ||
                                 out_last !== held_last)) hold_err++;
            if (stalls_left > 0 && int'(out_lane) == stall_lane) begin
               out_ready = 1'b0;
               stalls_left--;
            end else if (rand_rdy) begin
               out_ready = ($urandom_range(0, 2) != 0);
            end else begin
               out_ready = 1'b1;
            end
            if (out_ready) begin
               got_data.push_back(out_data);
               got_lane.push_back(int'(out_lane));
               got_last.push_back(out_last);
               prev_stalled = 0;
            end else begin
               held_data = out_data; held_lane = out_lane; held_last = out_last;
               prev_stalled = 1; stall_total++;
            end
         end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (done) begin
            done_cyc = cyc;
            done_pulses++;
            @(posedge clk); #1;
            break;
         end
         if (cyc > 800) begin
            timeout = 1;
            break;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_job(input string tag, input int l, input int wbv, input int abv,
                            input bit s, input int exp_done);
      logic [AW-1:0] e;
      vectors++;
      if (timeout !== 0) begin
         miscompares++; $display("FAIL %s timeout: got %0d required 0", tag, timeout);
      end
      vectors++;
      if (got_data.size() !== N) begin
         miscompares++; $display("FAIL %s lane_count: got %0d required %0d", tag, got_data.size(), N);
      end
      for (int i = 0; i < got_data.size() && i < N; i++) begin
         e = model_acc(i, l, wbv, abv, s);
         vectors++;
         if (got_data[i] !== e) begin
            miscompares++; $display("FAIL %s data lane%0d: got %h required %h", tag, i, got_data[i], e);
         end
         vectors++;
         if (got_lane[i] !== i || got_last[i] !== (i == N - 1)) begin
            miscompares++;
            $display("FAIL %s order idx%0d: got lane %0d last %0d required lane %0d last %0d",
                     tag, i, got_lane[i], got_last[i], i, (i == N - 1));
         end
      end
      vectors++;
      if (strobes !== l || en_err !== 0) begin
         miscompares++; $display("FAIL %s strobes: got %0d (en_err %0d) required %0d", tag, strobes, en_err, l);
      end
      vectors++;
      if (done_cyc !== exp_done || done_pulses !== 1) begin
         miscompares++; $display("FAIL %s done_cycle: got %0d required %0d", tag, done_cyc, exp_done);
      end
      vectors++;
      if (hold_err !== 0) begin
         miscompares++; $display("FAIL %s hold: got %0d unstable cycles required 0", tag, hold_err);
      end
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++; $display("FAIL %s post_idle: got busy %b done %b required 0 0", tag, busy, done);
      end
   endtask

   task automatic test_reset();
      vectors++;
      if ({busy, done, w_rd_en, a_rd_en, out_valid, out_last} !== 6'b0 ||
          out_data !== '0 || out_lane !== '0 || w_rd_addr !== '0 || a_rd_addr !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy %b done %b ren %b%b valid %b data %h required all 0",
                  busy, done, w_rd_en, a_rd_en, out_valid, out_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_idle: got busy %b required 0", busy);
      end
   endtask

   task automatic load_basic();
      fill_random();
      amem[10] = 8'd1; amem[11] = 8'd2; amem[12] = 8'd3;
      wmem[20] = {8'd4, 8'd3, 8'd2, 8'd1};
      wmem[21] = {8'd2, 8'd1, 8'd0, 8'hFF};
      wmem[22] = {8'd2, 8'd2, 8'd2, 8'd2};
   endtask

   task automatic test_basic();
      logic [AW-1:0] exp_v [4];
      exp_v[0] = 16'd5; exp_v[1] = 16'd8; exp_v[2] = 16'd11; exp_v[3] = 16'd14;
      load_basic();
      run_job(3, 20, 10, 1'b0, -1, 0, 1'b0, -1);
      check_job("basic", 3, 20, 10, 1'b0, 10);
      for (int i = 0; i < got_data.size() && i < N; i++) begin
         vectors++;
         if (got_data[i] !== exp_v[i]) begin
            miscompares++; $display("FAIL basic_const lane%0d: got %0d required %0d", i, got_data[i], exp_v[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      load_basic();
      run_job(3, 20, 10, 1'b0, 1, 3, 1'b0, -1);
      check_job("backpressure", 3, 20, 10, 1'b0, 13);
      vectors++;
      if (stall_total !== 3 || got_data.size() < 2 || got_data[1] !== 16'd8) begin
         miscompares++; $display("FAIL backpressure_lane1: got stalls %0d required 3 with data 8", stall_total);
      end
   endtask

   task automatic test_len0();
      load_basic();
      run_job(3, 20, 10, 1'b0, -1, 0, 1'b0, -1);
      run_job(0, 20, 10, 1'b0, -1, 0, 1'b0, -1);
      check_job("len0", 0, 20, 10, 1'b0, 6);
   endtask

   task automatic test_saturation();
      for (int i = 100; i < 104; i++) begin
         amem[i] = 8'd127;
         wmem[i] = {4{8'd127}};
      end
      run_job(4, 100, 100, 1'b1, -1, 0, 1'b0, -1);
      check_job("sat_on", 4, 100, 100, 1'b1, 11);
      vectors++;
      if (got_data.size() < 1 || got_data[0] !== 16'h7FFF) begin
         miscompares++; $display("FAIL sat_on_const: got %h required 7fff", got_data.size() ? got_data[0] : 16'hxxxx);
      end
      run_job(4, 100, 100, 1'b0, -1, 0, 1'b0, -1);
      check_job("sat_off", 4, 100, 100, 1'b0, 11);
      vectors++;
      if (got_data.size() < 4 || got_data[3] !== 16'hFC04) begin
         miscompares++; $display("FAIL sat_off_const: got %h required fc04", got_data.size() > 3 ? got_data[3] : 16'hxxxx);
      end
   endtask

   task automatic test_addr_wrap();
      fill_random();
      run_job(3, 255, 254, 1'b1, -1, 0, 1'b0, -1);
      check_job("wrap", 3, 255, 254, 1'b1, 10);
      for (int i = 0; i < wa_log.size() && i < 3; i++) begin
         vectors++;
         if (wa_log[i] !== (255 + i) % 256 || aa_log[i] !== (254 + i) % 256) begin
            miscompares++;
            $display("FAIL wrap_addr k%0d: got w %0d a %0d required w %0d a %0d",
                     i, wa_log[i], aa_log[i], (255 + i) % 256, (254 + i) % 256);
         end
      end
   endtask

   task automatic test_control();
      int seen_done;
      fill_random();
      run_job(6, 40, 90, 1'b0, -1, 0, 1'b0, 3);
      check_job("start_glitch", 6, 40, 90, 1'b0, 13);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL glitch_restart: got busy %b required 0", busy);
      end
      len = 8'd10; wb = 8'd7; ab = 8'd9; sat = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (w_rd_en !== 1'b1) begin
         miscompares++; $display("FAIL pre_abort_fetch: got ren %b required 1", w_rd_en);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, w_rd_en, a_rd_en, out_valid, out_last} !== 6'b0 ||
          out_data !== '0 || out_lane !== '0 || w_rd_addr !== '0 || a_rd_addr !== '0) begin
         miscompares++;
         $display("FAIL abort_outputs: got busy %b ren %b waddr %0d valid %b required all 0",
                  busy, w_rd_en, w_rd_addr, out_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) seen_done++;
         @(posedge clk); #1;
      end
      vectors++;
      if (seen_done !== 0) begin
         miscompares++; $display("FAIL abort_no_done: got %0d active cycles required 0", seen_done);
      end
      run_job(5, 200, 60, 1'b1, -1, 0, 1'b0, -1);
      check_job("after_abort", 5, 200, 60, 1'b1, 12);
   endtask

   task automatic test_random();
      int l, wbv, abv, exp_done;
      bit s;
      for (int j = 0; j < 25; j++) begin
         fill_random();
         l   = $urandom_range(0, 15);
         wbv = $urandom_range(0, 255);
         abv = $urandom_range(0, 255);
         s   = 1'($urandom_range(0, 1));
         run_job(l, wbv, abv, s, -1, 0, 1'b1, -1);
         exp_done = ((l == 0) ? 2 + N : l + 3 + N) + stall_total;
         check_job("random", l, wbv, abv, s, exp_done);
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst = 1'b1; start = 1'b0; len = '0; wb = '0; ab = '0; sat = 1'b0; out_ready = 1'b1;
      w_rd_data = '0; a_rd_data = '0;
      #12;
      test_reset();
      test_basic();
      test_backpressure();
      test_len0();
      test_saturation();
      test_addr_wrap();
      test_control();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
